// File: rtl/axi_mem_slv_pkg.sv
// rtl/axi_mem_slv_pkg.sv - shared response codes, burst types, FSM states and helpers for the AXI memory slave
package axi_mem_slv_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  // DECERR outranks SLVERR outranks OKAY, which matches the numeric order of the codes.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_mem_addr_gen.sv
// rtl/axi_mem_addr_gen.sv - combinational next-beat address, wrap boundary, burst legality and decode check
module axi_mem_addr_gen
  import axi_mem_slv_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 1024
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        len,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr,
  output logic              legal,
  output logic              in_range
);

  localparam int         WORD_LSB  = $clog2(DATA_W / 8);
  localparam logic [63:0] MEM_BYTES = 64'(MEM_DEPTH) * 64'(DATA_W / 8);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] wrap_mask;
  logic [ADDR_W-1:0] incr_addr;
  logic              wrap_len_ok;

  // Address step, wrap window and legality; an illegal burst parks on its start address.
  always_comb begin
    step        = ADDR_W'(1) << size;
    wrap_mask   = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    incr_addr   = addr + step;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    legal       = (burst != 2'b11) && (size <= 3'(WORD_LSB)) &&
                  ((burst != WRAP) || wrap_len_ok);
    in_range    = (64'(addr) < MEM_BYTES);
    next_addr   = addr;
    if (legal) begin
      case (burst)
        INCR:    next_addr = incr_addr;
        WRAP:    next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
        default: next_addr = addr;
      endcase
    end
  end

endmodule

// File: rtl/axi_burst_mem_slv.sv
// rtl/axi_burst_mem_slv.sv - AXI4 burst memory slave with independent write/read FSMs; stats ports via AXI_MEM_SLV_STATS_EN
module axi_burst_mem_slv
  import axi_mem_slv_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ID_W-1:0]     s_awid,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic [7:0]          s_awlen,
  input  logic [2:0]          s_awsize,
  input  logic [1:0]          s_awburst,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wlast,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [ID_W-1:0]     s_bid,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [ID_W-1:0]     s_arid,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic [7:0]          s_arlen,
  input  logic [2:0]          s_arsize,
  input  logic [1:0]          s_arburst,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [ID_W-1:0]     s_rid,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rlast,
  output logic                s_rvalid,
  input  logic                s_rready
`ifdef AXI_MEM_SLV_STATS_EN
  ,
  output logic [31:0]         wr_burst_cnt,
  output logic [31:0]         rd_burst_cnt,
  output logic [15:0]         err_cnt
`endif
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int WORD_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(MEM_DEPTH);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // ---------------- write channel ----------------
  wr_state_t         wr_state, wr_state_nxt;
  logic [ID_W-1:0]   wa_id;
  logic [ADDR_W-1:0] wa_addr;
  logic [7:0]        wa_len;
  logic [7:0]        wa_beat;
  logic [2:0]        wa_size;
  logic [1:0]        wa_burst;
  logic [1:0]        wa_resp;
  logic [ADDR_W-1:0] wg_next;
  logic              wg_legal;
  logic              wg_in_range;
  logic              aw_hs, w_hs, b_hs;
  logic              w_last_beat;
  logic [1:0]        w_beat_resp;

  assign aw_hs   = s_awvalid & s_awready;
  assign w_hs    = s_wvalid & s_wready;
  assign b_hs    = s_bvalid & s_bready;
  assign s_bid   = wa_id;
  assign s_bresp = wa_resp;

  axi_mem_addr_gen #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_wr_addr_gen (
    .addr      (wa_addr),
    .len       (wa_len),
    .size      (wa_size),
    .burst     (wa_burst),
    .next_addr (wg_next),
    .legal     (wg_legal),
    .in_range  (wg_in_range)
  );

  // Write FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) wr_state <= W_IDLE;
    else          wr_state <= wr_state_nxt;
  end

  // Write FSM next state and channel handshake outputs; one burst in flight at a time.
  always_comb begin
    wr_state_nxt = wr_state;
    s_awready    = 1'b0;
    s_wready     = 1'b0;
    s_bvalid     = 1'b0;
    case (wr_state)
      W_IDLE: begin
        s_awready = 1'b1;
        if (s_awvalid) wr_state_nxt = W_DATA;
      end
      W_DATA: begin
        s_wready = 1'b1;
        if (s_wvalid && w_last_beat) wr_state_nxt = W_RESP;
      end
      W_RESP: begin
        s_bvalid = 1'b1;
        if (s_bready) wr_state_nxt = W_IDLE;
      end
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  // Running burst response: wlast must appear exactly on beat len, and decode errors dominate.
  always_comb begin
    w_last_beat = (wa_beat == wa_len);
    w_beat_resp = wa_resp;
    if (!wg_legal || (s_wlast != w_last_beat)) w_beat_resp = resp_max(w_beat_resp, SLVERR);
    if (!wg_in_range)                          w_beat_resp = resp_max(w_beat_resp, DECERR);
  end

  // Latch AW fields, then advance address, beat count and accumulated response per W beat.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wa_id    <= '0;
      wa_addr  <= '0;
      wa_len   <= '0;
      wa_beat  <= '0;
      wa_size  <= '0;
      wa_burst <= '0;
      wa_resp  <= OKAY;
    end else if (aw_hs) begin
      wa_id    <= s_awid;
      wa_addr  <= s_awaddr;
      wa_len   <= s_awlen;
      wa_beat  <= '0;
      wa_size  <= s_awsize;
      wa_burst <= s_awburst;
      wa_resp  <= OKAY;
    end else if (w_hs) begin
      wa_addr  <= wg_next;
      wa_beat  <= wa_beat + 8'd1;
      wa_resp  <= w_beat_resp;
    end
  end

  // Byte-enabled array write; illegal bursts and out-of-range beats never touch the array.
  always_ff @(posedge aclk) begin
    if (w_hs && wg_legal && wg_in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_wstrb[b]) mem[wa_addr[WORD_LSB +: IDX_W]][8*b +: 8] <= s_wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  rd_state_t         rd_state, rd_state_nxt;
  logic [ADDR_W-1:0] ra_next;
  logic [7:0]        ra_len;
  logic [7:0]        ra_beat;
  logic [2:0]        ra_size;
  logic [1:0]        ra_burst;
  logic [ADDR_W-1:0] rg_addr;
  logic [7:0]        rg_len;
  logic [2:0]        rg_size;
  logic [1:0]        rg_burst;
  logic [ADDR_W-1:0] rg_next;
  logic              rg_legal;
  logic              rg_in_range;
  logic [1:0]        rg_resp;
  logic [DATA_W-1:0] rd_word;
  logic              ar_hs, r_hs, rd_load;

  assign ar_hs   = s_arvalid & s_arready;
  assign r_hs    = s_rvalid & s_rready;
  assign rd_load = ar_hs | (r_hs & ~s_rlast);
  assign rd_word = mem[rg_addr[WORD_LSB +: IDX_W]];

  // The shared generator looks at the AR bus for beat 0 and at the registered next address afterwards.
  always_comb begin
    rg_addr  = ra_next;
    rg_len   = ra_len;
    rg_size  = ra_size;
    rg_burst = ra_burst;
    if (rd_state == R_IDLE) begin
      rg_addr  = s_araddr;
      rg_len   = s_arlen;
      rg_size  = s_arsize;
      rg_burst = s_arburst;
    end
    rg_resp = OKAY;
    if (!rg_legal)    rg_resp = resp_max(rg_resp, SLVERR);
    if (!rg_in_range) rg_resp = resp_max(rg_resp, DECERR);
  end

  axi_mem_addr_gen #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_rd_addr_gen (
    .addr      (rg_addr),
    .len       (rg_len),
    .size      (rg_size),
    .burst     (rg_burst),
    .next_addr (rg_next),
    .legal     (rg_legal),
    .in_range  (rg_in_range)
  );

  // Read FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rd_state <= R_IDLE;
    else          rd_state <= rd_state_nxt;
  end

  // Read FSM next state and handshake outputs.
  always_comb begin
    rd_state_nxt = rd_state;
    s_arready    = 1'b0;
    s_rvalid     = 1'b0;
    case (rd_state)
      R_IDLE: begin
        s_arready = 1'b1;
        if (s_arvalid) rd_state_nxt = R_DATA;
      end
      R_DATA: begin
        s_rvalid = 1'b1;
        if (s_rready && s_rlast) rd_state_nxt = R_IDLE;
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  // Registered beat: loaded on AR accept and on each non-final R handshake, otherwise held.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_rid    <= '0;
      s_rdata  <= '0;
      s_rresp  <= OKAY;
      s_rlast  <= 1'b0;
      ra_next  <= '0;
      ra_len   <= '0;
      ra_beat  <= '0;
      ra_size  <= '0;
      ra_burst <= '0;
    end else begin
      if (ar_hs) begin
        s_rid    <= s_arid;
        ra_len   <= s_arlen;
        ra_size  <= s_arsize;
        ra_burst <= s_arburst;
        ra_beat  <= '0;
        s_rlast  <= (s_arlen == 8'd0);
      end else if (r_hs && !s_rlast) begin
        ra_beat  <= ra_beat + 8'd1;
        s_rlast  <= ((ra_beat + 8'd1) == ra_len);
      end
      if (rd_load) begin
        s_rdata <= (rg_resp == OKAY) ? rd_word : '0;
        s_rresp <= rg_resp;
        ra_next <= rg_next;
      end
    end
  end

`ifdef AXI_MEM_SLV_STATS_EN
  logic       rd_err_seen;
  logic       rd_burst_err;
  logic [1:0] err_inc;

  // A read burst counts as errored if any of its beats carried a non-OKAY response.
  always_comb begin
    rd_burst_err = r_hs && s_rlast && (rd_err_seen || (s_rresp != OKAY));
    err_inc      = {1'b0, b_hs && (s_bresp != OKAY)} + {1'b0, rd_burst_err};
  end

  // Saturating burst and error counters.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_burst_cnt <= '0;
      rd_burst_cnt <= '0;
      err_cnt      <= '0;
      rd_err_seen  <= 1'b0;
    end else begin
      if (b_hs && (wr_burst_cnt != '1))            wr_burst_cnt <= wr_burst_cnt + 32'd1;
      if (r_hs && s_rlast && (rd_burst_cnt != '1)) rd_burst_cnt <= rd_burst_cnt + 32'd1;
      if (r_hs) rd_err_seen <= s_rlast ? 1'b0 : (rd_err_seen | (s_rresp != OKAY));
      if (err_cnt > (16'hFFFF - 16'(err_inc))) err_cnt <= 16'hFFFF;
      else                                     err_cnt <= err_cnt + 16'(err_inc);
    end
  end
`endif

endmodule

// File: tb/tb_axi_burst_mem_slv.sv
// tb/tb_axi_burst_mem_slv.sv - directed scoreboard bench for axi_burst_mem_slv
module tb_axi_burst_mem_slv;
  import axi_mem_slv_pkg::*;

  localparam int TMO = 50;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  s_awid;
  logic [15:0] s_awaddr;
  logic [7:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst;
  logic        s_awvalid, s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wlast, s_wvalid, s_wready;
  logic [3:0]  s_bid;
  logic [1:0]  s_bresp;
  logic        s_bvalid, s_bready;
  logic [3:0]  s_arid;
  logic [15:0] s_araddr;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic        s_arvalid, s_arready;
  logic [3:0]  s_rid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast, s_rvalid, s_rready;
`ifdef AXI_MEM_SLV_STATS_EN
  logic [31:0] wr_burst_cnt, rd_burst_cnt;
  logic [15:0] err_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  rbeat_t     r_exp[$];
  logic [1:0] b_exp[$];
  logic [31:0] wd_q[$];
  logic [3:0]  ws_q[$];
  logic        wl_q[$];

  axi_burst_mem_slv #(
    .ADDR_W(16), .DATA_W(32), .ID_W(4), .MEM_DEPTH(1024)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready)
`ifdef AXI_MEM_SLV_STATS_EN
    , .wr_burst_cnt(wr_burst_cnt), .rd_burst_cnt(rd_burst_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wbeat(input logic [31:0] d, input logic [3:0] s, input logic l);
    wd_q.push_back(d);
    ws_q.push_back(s);
    wl_q.push_back(l);
  endtask

  task automatic rexp(input logic [31:0] d, input logic [1:0] r, input logic l);
    rbeat_t e;
    e.data = d;
    e.resp = r;
    e.last = l;
    r_exp.push_back(e);
  endtask

  task automatic do_write(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [1:0] resp);
    int n;
    b_exp.push_back(resp);
    @(negedge aclk);
    s_awvalid = 1'b1; s_awid = id; s_awaddr = addr; s_awlen = len; s_awsize = size; s_awburst = burst;
    n = 0;
    while (!s_awready && n < TMO) begin @(negedge aclk); n++; end
    check("aw_handshake", 64'(n < TMO), 1);
    @(negedge aclk);
    s_awvalid = 1'b0;
    while (wd_q.size() > 0) begin
      s_wvalid = 1'b1;
      s_wdata  = wd_q.pop_front();
      s_wstrb  = ws_q.pop_front();
      s_wlast  = wl_q.pop_front();
      n = 0;
      while (!s_wready && n < TMO) begin @(negedge aclk); n++; end
      check("w_handshake", 64'(n < TMO), 1);
      @(negedge aclk);
    end
    s_wvalid = 1'b0;
    s_wlast  = 1'b0;
    check("w_no_extra_beat", s_wready, 0);
    s_bready = 1'b1;
    n = 0;
    while (!s_bvalid && n < TMO) begin @(negedge aclk); n++; end
    check("b_valid", 64'(n < TMO), 1);
    check("bid", s_bid, id);
    check("bresp", s_bresp, b_exp.pop_front());
    @(negedge aclk);
    s_bready = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input int stall_beat, input int stall_cycles);
    int n;
    rbeat_t e;
    logic [38:0] snap;
    @(negedge aclk);
    s_arvalid = 1'b1; s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst;
    n = 0;
    while (!s_arready && n < TMO) begin @(negedge aclk); n++; end
    check("ar_handshake", 64'(n < TMO), 1);
    @(negedge aclk);
    s_arvalid = 1'b0;
    check("r_first_latency", s_rvalid, 1);
    for (int i = 0; i <= int'(len); i++) begin
      if (i == stall_beat) begin
        s_rready = 1'b0;
        snap = {s_rid, s_rdata, s_rresp, s_rlast};
        for (int k = 0; k < stall_cycles; k++) begin
          @(negedge aclk);
          check("r_stall_stable", {s_rvalid, s_rid, s_rdata, s_rresp, s_rlast}, {1'b1, snap});
        end
      end
      s_rready = 1'b1;
      n = 0;
      while (!s_rvalid && n < TMO) begin @(negedge aclk); n++; end
      check("r_valid", 64'(n < TMO), 1);
      e = r_exp.pop_front();
      check("rid", s_rid, id);
      check("rdata", s_rdata, e.data);
      check("rresp", s_rresp, e.resp);
      check("rlast", s_rlast, e.last);
      @(negedge aclk);
    end
    s_rready = 1'b0;
    check("r_done_idle", {s_rvalid, s_arready}, 2'b01);
  endtask

  initial begin
    int n;
    aresetn = 1'b0;
    s_awvalid = 0; s_awid = 0; s_awaddr = 0; s_awlen = 0; s_awsize = 0; s_awburst = 0;
    s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_wlast = 0; s_bready = 0;
    s_arvalid = 0; s_arid = 0; s_araddr = 0; s_arlen = 0; s_arsize = 0; s_arburst = 0;
    s_rready = 0;
    repeat (3) @(negedge aclk);
    check("rst_awready", s_awready, 1);
    check("rst_arready", s_arready, 1);
    check("rst_wready", s_wready, 0);
    check("rst_bvalid", s_bvalid, 0);
    check("rst_rvalid", s_rvalid, 0);
    check("rst_bresp", s_bresp, OKAY);
    check("rst_rresp", s_rresp, OKAY);
    check("rst_rdata", s_rdata, 0);
    aresetn = 1'b1;

    // INCR write then read back
    for (int i = 0; i < 4; i++) wbeat(32'hA0 + 32'(i), 4'hF, i == 3);
    do_write(4'd5, 16'h0010, 8'd3, 3'd2, INCR, OKAY);
    for (int i = 0; i < 4; i++) rexp(32'hA0 + 32'(i), OKAY, i == 3);
    do_read(4'd3, 16'h0010, 8'd3, 3'd2, INCR, -1, 0);

    // WRAP read over a preloaded window, then illegal WRAP length and oversize beat
    for (int i = 0; i < 4; i++) wbeat(32'h30 + 32'(4 * i), 4'hF, i == 3);
    do_write(4'd1, 16'h0030, 8'd3, 3'd2, INCR, OKAY);
    rexp(32'h38, OKAY, 0); rexp(32'h3C, OKAY, 0); rexp(32'h30, OKAY, 0); rexp(32'h34, OKAY, 1);
    do_read(4'd2, 16'h0038, 8'd3, 3'd2, WRAP, -1, 0);
    for (int i = 0; i < 3; i++) rexp(32'h0, SLVERR, i == 2);
    do_read(4'd2, 16'h0038, 8'd2, 3'd2, WRAP, -1, 0);
    rexp(32'h0, SLVERR, 1);
    do_read(4'd4, 16'h0010, 8'd0, 3'd3, INCR, -1, 0);

    // Partial strobes
    wbeat(32'h11223344, 4'hF, 1);
    do_write(4'd6, 16'h0040, 8'd0, 3'd2, INCR, OKAY);
    wbeat(32'hDEADBEEF, 4'b0101, 1);
    do_write(4'd6, 16'h0040, 8'd0, 3'd2, INCR, OKAY);
    rexp(32'h11AD33EF, OKAY, 1);
    do_read(4'd6, 16'h0040, 8'd0, 3'd2, INCR, -1, 0);

    // Decode errors: out-of-range write leaves memory alone; read straddling the top
    wbeat(32'hCAFE0000, 4'hF, 1);
    do_write(4'd8, 16'h0000, 8'd0, 3'd2, INCR, OKAY);
    wbeat(32'hFFFFFFFF, 4'hF, 1);
    do_write(4'd9, 16'h1000, 8'd0, 3'd2, INCR, DECERR);
    rexp(32'hCAFE0000, OKAY, 1);
    do_read(4'd8, 16'h0000, 8'd0, 3'd2, INCR, -1, 0);
    wbeat(32'h12345678, 4'hF, 1);
    do_write(4'd10, 16'h0FFC, 8'd0, 3'd2, INCR, OKAY);
    rexp(32'h12345678, OKAY, 0); rexp(32'h0, DECERR, 1);
    do_read(4'd11, 16'h0FFC, 8'd1, 3'd2, INCR, -1, 0);

    // Reserved burst type must not write; stalled read shows the original data
    wbeat(32'hFFFFFFFF, 4'hF, 1);
    do_write(4'd12, 16'h0010, 8'd0, 3'd2, 2'b11, SLVERR);
    for (int i = 0; i < 4; i++) rexp(32'hA0 + 32'(i), OKAY, i == 3);
    do_read(4'd13, 16'h0010, 8'd3, 3'd2, INCR, 1, 5);

    // wlast on beat 1 of a four-beat burst
    wbeat(32'h1, 4'hF, 0); wbeat(32'h2, 4'hF, 1); wbeat(32'h3, 4'hF, 0); wbeat(32'h4, 4'hF, 0);
    do_write(4'd14, 16'h0050, 8'd3, 3'd2, INCR, SLVERR);

    // Reset in the middle of a write burst
    @(negedge aclk);
    s_awvalid = 1'b1; s_awid = 4'd15; s_awaddr = 16'h0060; s_awlen = 8'd3; s_awsize = 3'd2; s_awburst = INCR;
    n = 0;
    while (!s_awready && n < TMO) begin @(negedge aclk); n++; end
    check("abort_aw_handshake", 64'(n < TMO), 1);
    @(negedge aclk);
    s_awvalid = 1'b0;
    s_wvalid = 1'b1; s_wdata = 32'h55; s_wstrb = 4'hF; s_wlast = 1'b0;
    @(negedge aclk);
    s_wvalid = 1'b0;
    check("abort_in_wdata", s_wready, 1);
    aresetn = 1'b0;
    #1;
    check("abort_bvalid", s_bvalid, 0);
    check("abort_awready", s_awready, 1);
    check("abort_wready", s_wready, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    wbeat(32'h77, 4'hF, 1);
    do_write(4'd7, 16'h0060, 8'd0, 3'd2, INCR, OKAY);
    rexp(32'h77, OKAY, 1);
    do_read(4'd7, 16'h0060, 8'd0, 3'd2, INCR, -1, 0);
`ifdef AXI_MEM_SLV_STATS_EN
    check("stats_wr_burst_cnt", wr_burst_cnt, 1);
    check("stats_rd_burst_cnt", rd_burst_cnt, 1);
    check("stats_err_cnt", err_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_burst_mem_slv.md
Name: axi_burst_mem_slv

Overview:
- Synthesizable AXI4 memory slave, downstream of the passthrough stage inside chip.
- Terminates the AXI4 traffic that the master and passthrough VIPs generate.
- Provides a word-addressed on-chip memory with independent write and read channel FSMs.
- Its B/R responses are what the bench scoreboards compare against the master-side monitor.

Parameters:
- ADDR_W, 16: byte address width.
- DATA_W, 32: data bus width, 32 or 64.
- ID_W, 4: AXI ID width.
- MEM_DEPTH, 1024: number of DATA_W words; byte range 0 .. MEM_DEPTH*DATA_W/8-1.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_awid/awaddr/awlen/awsize/awburst  in  ID_W/ADDR_W/8/3/2  write address
- s_awvalid in 1; s_awready out 1
- s_wdata/wstrb/wlast  in  DATA_W/DATA_W/8/1  write data
- s_wvalid in 1; s_wready out 1
- s_bid/bresp  out  ID_W/2  write response
- s_bvalid out 1; s_bready in 1
- s_arid/araddr/arlen/arsize/arburst  in  ID_W/ADDR_W/8/3/2  read address
- s_arvalid in 1; s_arready out 1
- s_rid/rdata/rresp/rlast  out  ID_W/DATA_W/2/1  read data
- s_rvalid out 1; s_rready in 1

Behaviour:
- Reset (async assert, sync release): all valids 0; awready=arready=1; wready=0; bresp/rresp=OKAY; rdata=0; FSMs idle. Memory contents not reset.
- Reset mid-burst: burst is abandoned immediately; no B/R is issued for it.
- Write FSM:
  - W_IDLE: accept AW when awvalid&awready; latch id, addr, len, size, burst, beat_cnt=0; go to W_DATA, awready=0, wready=1.
  - W_DATA: each w handshake writes the bytes enabled by wstrb at the current word; address advances per burst type; beat_cnt increments.
  - Leave W_DATA on the beat where beat_cnt==len. The response error is SLVERR if wlast is absent on that beat or was asserted earlier. Extra beats are never consumed.
  - W_RESP: bvalid=1 until bready; then W_IDLE, awready=1. No AW is accepted during W_DATA or W_RESP (single outstanding write).
- Read FSM:
  - R_IDLE: accept AR, latch fields; go to R_DATA, arready=0.
  - R_DATA: the first rvalid appears 1 cycle after AR handshake (registered memory read). Beats then issue back-to-back while rready=1.
  - rdata, rresp, rlast and rid are held stable while rvalid&!rready. rlast is set on beat len.
  - After the last beat handshake: R_IDLE, arready=1 on the following cycle.
- Burst arithmetic:
  - Word index = addr[..] >> log2(DATA_W/8). Unaligned start: the address is aligned down for the memory access; wstrb still governs which bytes are written.
  - FIXED: address constant.
  - INCR: addr += 2^size.
  - WRAP: legal for len in {1,3,7,15}. Wrap boundary = (len+1)*2^size aligned. Illegal WRAP len gives SLVERR for the whole burst, with no writes and zero read data.
  - Reserved burst type (2'b11) gives SLVERR.
  - awsize/arsize > log2(DATA_W/8) gives SLVERR.
- Decode: any beat address ≥ MEM_DEPTH*DATA_W/8 gives DECERR for that beat (reads) or the burst (writes). Those write beats are dropped and those reads return rdata=0. In-range beats still execute.
- Response priority: DECERR > SLVERR > OKAY. bresp reports the worst seen in the burst.
- Simultaneous write and read to the same word in the same cycle: the read returns the pre-write data.
- The write and read FSMs are fully independent; there is no arbitration.

Optional Feature:
- Macro AXI_MEM_SLV_STATS_EN.
- Defined: adds output ports wr_burst_cnt[31:0], rd_burst_cnt[31:0] and err_cnt[15:0].
  - wr_burst_cnt increments on the B handshake; rd_burst_cnt increments on the last R handshake.
  - err_cnt increments on each non-OKAY B, and on each read burst containing any non-OKAY beat.
  - All three counters reset to 0 and saturate at their maximum.
- Undefined: these ports and their logic are absent.

Decomposition:
- Package axi_mem_slv_pkg:
  - resp constants OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11;
  - burst enum FIXED/INCR/WRAP;
  - wr_state_t {W_IDLE,W_DATA,W_RESP} and rd_state_t {R_IDLE,R_DATA};
  - function resp_max().
- Sub-module axi_mem_addr_gen: combinational next-address, wrap boundary and legality/decode check. It is instantiated twice, once for write and once for read.

Test Plan:
- INCR write awaddr=0x0010, len=3, size=2, data 0xA0..A3, full strb; then INCR read from the same address -> bresp=OKAY, bid echoed; rdata 0xA0,0xA1,0xA2,0xA3; rlast on beat 3; first rvalid 1 cycle after AR.
- WRAP read araddr=0x0038, len=3, size=2 (memory preloaded) -> beats at 0x38, 0x3C, 0x30, 0x34. WRAP with len=2 -> rresp=SLVERR on every beat, rdata=0.
- Write with wstrb=4'b0101, data 0xDEADBEEF over 0x11223344 -> read returns 0x11AD33EF.
- Write to 0x1000 (DEPTH 1024, 32-bit) -> bresp=DECERR and memory unchanged. Read burst of len=1 at 0x0FFC -> beat0 OKAY, beat1 DECERR with rdata 0.
- rready held low for 5 cycles mid-burst, and wlast asserted on beat 1 of a len=3 write -> R signals stable throughout; bresp=SLVERR after 4 beats.
- aresetn pulsed low during W_DATA -> bvalid=0, awready=1 immediately; next write completes OKAY. With AXI_MEM_SLV_STATS_EN, wr_burst_cnt excludes the aborted burst.
